// File: rtl/rr_mux2_arb.sv
// rr_mux2_arb: round-robin two-source valid/ready arbiter feeding a single registered output stage
module rr_mux2_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             load, grant_a, grant_b;

    assign load    = !out_valid_q || out_ready;
    // on a tie the source that was not granted last wins
    assign grant_a = a_valid && (!b_valid || last_q);
    assign grant_b = b_valid && (!a_valid || !last_q);
    // nothing is accepted while reset is held, so no word is lost on release
    assign a_ready = rst_n && load && grant_a;
    assign b_ready = rst_n && load && grant_b;

    always_comb begin
        out_valid_d = a_ready || b_ready || (out_valid_q && !out_ready);
        out_data_d  = a_ready ? a_data : b_ready ? b_data : out_data_q;
        sel_d       = (a_ready || b_ready) ? b_ready : sel_q;
        last_d      = (a_ready || b_ready) ? b_ready : last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
endmodule
